mult_serial_host: RTL

- Host-side counterpart of the serial Booth-multiplier link.
- Accepts one parallel operand pair and shifts both operands out as two lockstep serial streams with a per-bit valid/ready handshake.
- Then collects the 2*DATA_WIDTH-bit serial product returned by the multiplier and presents it in parallel with a valid/ready handshake.
- Sits between a parallel requester (CPU model or test sequencer) and the multiplier's serial pins.

---
 rtl/mult_serial_host.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mult_serial_host.sv
// mult_serial_host: host side of the serial Booth-multiplier link.
// Takes one parallel operand pair, shifts both operands out LSB first as two
// lockstep serial streams, then gathers the 2*DATA_WIDTH-bit serial product
// and presents it in parallel.
// Optional watchdog in S_RECV: define MULT_HOST_TIMEOUT_EN to compile it in.
module mult_serial_host #(
  parameter int DATA_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [DATA_WIDTH-1:0]   iv_a,
  input  logic [DATA_WIDTH-1:0]   iv_b,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  output logic                    o_ser_a,
  output logic                    o_ser_b,
  output logic                    o_ser_valid,
  input  logic                    i_ser_ready,
  input  logic                    i_prod,
  input  logic                    i_prod_valid,
  output logic                    o_prod_ready,
  output logic [2*DATA_WIDTH-1:0] ov_prod,
  output logic                    o_prod_valid,
  input  logic                    i_prod_ready
`ifdef MULT_HOST_TIMEOUT_EN
  ,
  output logic                    o_timeout
`endif
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(PW + 1);
  localparam logic [CNT_W-1:0] LAST_SEND = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_RECV = CNT_W'(PW - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] a_sr, b_sr;
  logic [PW-1:0]         prod_sr;
  logic [CNT_W-1:0]      cnt;

  logic req_xfer, send_beat, recv_beat, res_xfer;
  logic send_last, recv_last, wd_hit;

  // Transfer qualifiers; nothing moves while the block is disabled.
  assign req_xfer  = i_en & i_req_valid  & (state == S_IDLE);
  assign send_beat = i_en & i_ser_ready  & (state == S_SEND);
  assign recv_beat = i_en & i_prod_valid & (state == S_RECV);
  assign res_xfer  = i_en & i_prod_ready & (state == S_DONE);
  assign send_last = send_beat & (cnt == LAST_SEND);
  assign recv_last = recv_beat & (cnt == LAST_RECV);

`ifdef MULT_HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;

  // Fires on the idle S_RECV cycle that completes TIMEOUT_CYCLES of silence.
  assign wd_hit = i_en & (state == S_RECV) & ~i_prod_valid & (wd == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts consecutive silent S_RECV cycles; any receive beat clears it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wd        <= '0;
      o_timeout <= 1'b0;
    end else if (i_en) begin
      o_timeout <= wd_hit;
      if (state == S_RECV && !recv_beat && !wd_hit) wd <= wd + WD_W'(1);
      else                                          wd <= '0;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  state <= S_IDLE;
    else if (i_en) state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_xfer)  state_nxt = S_SEND;
      S_SEND: if (send_last) state_nxt = S_RECV;
      S_RECV: begin
        if (recv_last)   state_nxt = S_DONE;
        else if (wd_hit) state_nxt = S_IDLE;
      end
      S_DONE: if (res_xfer)  state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // Handshake and serial outputs decoded from the registered state.
  always_comb begin
    o_req_ready  = (state == S_IDLE);
    o_ser_valid  = (state == S_SEND);
    o_ser_a      = (state == S_SEND) & a_sr[0];
    o_ser_b      = (state == S_SEND) & b_sr[0];
    o_prod_ready = (state == S_RECV);
    o_prod_valid = (state == S_DONE);
  end

  // Operand/product shift registers, bit counter and the parallel result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      prod_sr <= '0;
      ov_prod <= '0;
      cnt     <= '0;
    end else if (i_en) begin
      case (state)
        S_IDLE: begin
          if (req_xfer) begin
            a_sr <= iv_a;
            b_sr <= iv_b;
            cnt  <= '0;
          end
        end
        S_SEND: begin
          if (send_beat) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            cnt  <= send_last ? '0 : cnt + CNT_W'(1);
          end
        end
        S_RECV: begin
          if (recv_beat) begin
            // First bit received ends up in bit 0 after PW right shifts.
            prod_sr <= {i_prod, prod_sr[PW-1:1]};
            cnt     <= recv_last ? '0 : cnt + CNT_W'(1);
            if (recv_last) ov_prod <= {i_prod, prod_sr[PW-1:1]};
          end else if (wd_hit) begin
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
